dbg_capture_buf: RTL and testbench

Parametrised on-chip debug capture engine, successor to the fixed-width register-and-probe debug wrapper.
- Registers NUM_CH probe channels each cycle and evaluates a masked-compare trigger on one selectable channel.
- Stores a pre/post-trigger window in a circular buffer, then streams the window out over a valid/ready port.
- Used for flash-controller and similar bring-up where an external ILA is unavailable or too narrow.

---
 rtl/dbg_capture_pkg.sv | 22 ++
 rtl/dbg_capture_ram.sv | 27 ++
 rtl/dbg_capture_buf.sv | 168 ++++++++++++++++
 tb/tb_dbg_capture_buf.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dbg_capture_pkg.sv
// Shared types and helpers for the debug capture engine.
// DBG_CAPTURE_TIMESTAMP_EN (when defined) selects the timestamped entry format.
package dbg_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam int TS_W_DEF = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dbg_capture_ram.sv
// Simple dual-port capture storage: one write port, one registered read port.
module dbg_capture_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 64,
    parameter int AW    = 10
) (
    input  logic          v_clk0,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge v_clk0) begin
        if (we) mem[waddr] <= wdata;
    end

    // No reset on the read register so it maps onto block RAM output flops.
    always_ff @(posedge v_clk0) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dbg_capture_buf.sv
// Debug capture engine: registered probes, masked trigger, pre/post window, streamed readout.
// Define DBG_CAPTURE_TIMESTAMP_EN to prepend a TS_W-bit cycle timestamp to every entry.
module dbg_capture_buf
    import dbg_capture_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 64,
    parameter int DEPTH  = 1024,
    parameter int PRE    = 256,
`ifdef DBG_CAPTURE_TIMESTAMP_EN
    parameter int TS_W   = TS_W_DEF,
    localparam int EW    = NUM_CH*CH_W + TS_W,
`else
    localparam int EW    = NUM_CH*CH_W,
`endif
    localparam int SW    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                   v_clk0,
    input  logic                   v_rst0,
    input  logic [NUM_CH*CH_W-1:0] v_debug_in,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [SW-1:0]          trig_sel,
    input  logic [CH_W-1:0]        trig_mask,
    input  logic [CH_W-1:0]        trig_value,
    output logic [EW-1:0]          rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic [1:0]             state,
    output logic                   done
);

    localparam int DW = NUM_CH*CH_W;
    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PRE_A   = AW'(PRE);
    localparam logic [AW-1:0] POST_N  = AW'(DEPTH - PRE - 1);
    localparam logic [AW:0]   PRE_F   = (AW+1)'(PRE);
    localparam logic [AW:0]   DEPTH_F = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_F  = (AW+1)'(DEPTH - 1);

    logic [DW-1:0]   reg_q;
    state_t          st_q, st_d;
    logic [AW-1:0]   wr_ptr, trig_ptr, post_cnt, rd_ptr;
    logic [AW:0]     fill, rd_cnt;
    logic [CH_W-1:0] sel_ch;
    logic            sel_ok, hit, qual, we, re;
    logic [EW-1:0]   wdata, ram_q;

    always_ff @(posedge v_clk0) reg_q <= v_debug_in;

`ifdef DBG_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    always_ff @(posedge v_clk0) begin
        if (v_rst0) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end
    assign wdata = {ts_q, reg_q};
`else
    assign wdata = reg_q;
`endif

    // Out-of-range selects never match.
    always_comb begin
        sel_ch = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(trig_sel) == k) begin
                sel_ch = reg_q[k*CH_W +: CH_W];
                sel_ok = 1'b1;
            end
        end
    end

    assign hit  = sel_ok && (((sel_ch ^ trig_value) & trig_mask) == '0);
    assign qual = hit && (fill >= PRE_F);

    always_comb begin
        st_d = st_q;
        we   = 1'b0;
        re   = 1'b0;
        case (st_q)
            ST_IDLE:  if (arm) st_d = ST_ARMED;
            ST_ARMED: begin
                we = 1'b1;
                if (qual) st_d = (POST_N == '0) ? ST_READ : ST_POST;
            end
            ST_POST: begin
                we = 1'b1;
                if (post_cnt == AW'(1)) st_d = ST_READ;
            end
            ST_READ: begin
                re = (!rd_valid || rd_ready) && (rd_cnt != DEPTH_F);
                if (rd_valid && rd_ready && rd_last) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
        if (abort) begin
            st_d = ST_IDLE;
            we   = 1'b0;
            re   = 1'b0;
        end
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            st_q     <= ST_IDLE;
            wr_ptr   <= '0;
            fill     <= '0;
            trig_ptr <= '0;
            post_cnt <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == ST_IDLE && arm) begin
                wr_ptr <= '0;
                fill   <= '0;
            end
            if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != DEPTH_F) fill <= fill + 1'b1;
            end
            if (st_q == ST_ARMED && qual) begin
                trig_ptr <= wr_ptr;
                post_cnt <= POST_N;
            end else if (we && st_q == ST_POST) begin
                post_cnt <= post_cnt - 1'b1;
            end
            // When jumping straight from ARMED the trigger is the slot written this cycle.
            if (st_d == ST_READ && st_q != ST_READ) begin
                rd_ptr <= ((st_q == ST_ARMED) ? wr_ptr : trig_ptr) - PRE_A;
                rd_cnt <= '0;
            end else if (re) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (abort) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else if (re) begin
                rd_valid <= 1'b1;
                rd_last  <= (rd_cnt == LAST_F);
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

    dbg_capture_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
        .v_clk0 (v_clk0),
        .we     (we),
        .waddr  (wr_ptr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (rd_ptr),
        .rdata  (ram_q)
    );

    // RAM read data is only advanced on a fetch, so it stays put during a stall.
    assign rd_data = rd_valid ? ram_q : '0;
    assign state   = st_q;
    assign done    = (st_q == ST_READ);

endmodule

// File: tb/tb_dbg_capture_buf.sv
// Directed + randomized bench for dbg_capture_buf; windows predicted from the driven probe stream.
module tb_dbg_capture_buf;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 8;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int DW     = NUM_CH*CH_W;
    localparam int SLEN   = 1024;
`ifdef DBG_CAPTURE_TIMESTAMP_EN
    localparam int TS_W   = 16;
    localparam int EW     = DW + TS_W;
`else
    localparam int EW     = DW;
`endif

    logic          v_clk0 = 1'b0;
    logic          v_rst0 = 1'b1;
    logic [DW-1:0] v_debug_in = '0;
    logic          arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [0:0]    trig_sel = '0;
    logic [7:0]    trig_mask = '0, trig_value = '0;
    logic [EW-1:0] rd_data;
    logic          rd_valid, rd_last, done;
    logic [1:0]    state;

    logic [DW-1:0] stream [SLEN];
    int k = 0;
    int cyc = 0;
    int checks = 0, errors = 0;

    dbg_capture_buf #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH),
`ifdef DBG_CAPTURE_TIMESTAMP_EN
        .TS_W(TS_W),
`endif
        .PRE(PRE)
    ) dut (
        .v_clk0(v_clk0), .v_rst0(v_rst0), .v_debug_in(v_debug_in),
        .arm(arm), .abort(abort), .trig_sel(trig_sel),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last), .state(state), .done(done)
    );

    always #5 v_clk0 = ~v_clk0;

    // Free-running cycle count, cleared by reset like the timestamp counter.
    always @(posedge v_clk0) begin
        if (v_rst0) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; probes follow the stream, outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge v_clk0);
        #1;
        if (k < SLEN-1) k++;
        v_debug_in = stream[k];
    endtask

    function automatic logic [7:0] chan(input int i, input int sel);
        logic [DW-1:0] s;
        s = stream[i];
        return sel[0] ? s[15:8] : s[7:0];
    endfunction

    // Sample i of a capture is stream[i]; trigger is the first match at or beyond PRE samples.
    function automatic int find_trig(input int sel, input logic [7:0] mask, input logic [7:0] val);
        for (int i = PRE; i < SLEN - 2*DEPTH; i++)
            if (((chan(i, sel) ^ val) & mask) == 8'h00) return i;
        return -1;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < SLEN; i++) stream[i] = {8'(~i), 8'(i)};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < SLEN; i++) stream[i] = DW'($urandom);
    endtask

    task automatic start(input int sel, input logic [7:0] mask, input logic [7:0] val, output int c_arm);
        trig_sel   = 1'(sel);
        trig_mask  = mask;
        trig_value = val;
        rd_ready   = 1'b0;
        k          = 0;
        v_debug_in = stream[0];
        arm        = 1'b1;
        c_arm      = cyc;
        step();
        arm = 1'b0;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic capture(input string tag, input int sel, input logic [7:0] mask,
                           input logic [7:0] val, input int mode, input int rst_after);
        int ti, got, guard, c_arm, fv;
        logic stalled;
        logic [EW-1:0] hold;
        logic [DW-1:0] exp_s;
        ti = find_trig(sel, mask, val);
        start(sel, mask, val, c_arm);
        chk({tag, "_armed"}, 64'(state), 64'd1);
        guard = 0;
        while (state != 2'd3 && guard < 2000) begin step(); guard++; end
        chk({tag, "_reach_read"}, 64'(state), 64'd3);
        got = 0; guard = 0; stalled = 1'b0; fv = -1; hold = '0;
        while (got < DEPTH && guard < 400) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = (guard % 4 == 0) || (guard % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (rd_valid && fv < 0) fv = guard;
            if (guard == 2) chk({tag, "_first_valid_by_2"}, 64'(fv >= 0), 64'd1);
            if (stalled) chk({tag, "_stall_hold"}, 64'({rd_valid, rd_data}), 64'({1'b1, hold}));
            if (rd_valid && rd_ready) begin
                exp_s = stream[ti - PRE + got];
                chk({tag, "_data"}, 64'(rd_data[DW-1:0]), 64'(exp_s));
                chk({tag, "_last"}, 64'(rd_last), 64'(got == DEPTH-1));
`ifdef DBG_CAPTURE_TIMESTAMP_EN
                chk({tag, "_ts"}, 64'(rd_data[EW-1:DW]), 64'(16'(c_arm + 1 + ti - PRE + got)));
`endif
                got++;
                if (got == rst_after) begin
                    step();
                    v_rst0 = 1'b1;
                    step();
                    v_rst0 = 1'b0;
                    chk({tag, "_rst_state"}, 64'(state), 64'd0);
                    chk({tag, "_rst_valid"}, 64'(rd_valid), 64'd0);
                    chk({tag, "_rst_last_done"}, 64'({rd_last, done}), 64'd0);
                    return;
                end
            end
            stalled = rd_valid && !rd_ready;
            hold    = rd_data;
            step();
            guard++;
        end
        rd_ready = 1'b0;
        chk({tag, "_count"}, 64'(got), 64'(DEPTH));
        chk({tag, "_idle_after"}, 64'({state, rd_valid, done}), 64'd0);
    endtask

    initial begin : main
        int c_arm, guard, ti;
        logic saw_valid;
        logic [7:0] m, v;
        fill_ramp();
        v_rst0 = 1'b1;
        repeat (2) step();
        v_rst0 = 1'b0;
        chk("reset_state", 64'({state, done}), 64'd0);
        chk("reset_rd", 64'({rd_valid, rd_last}), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);

        // arm together with abort: abort wins, stays idle
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_same", 64'(state), 64'd0);

        capture("ramp20", 0, 8'hFF, 8'd20, 0, -1);
        capture("early_hit", 0, 8'hFF, 8'd2, 0, -1);
        capture("stall", 0, 8'hFF, 8'd20, 1, -1);

        // abort three cycles into POST
        start(0, 8'hFF, 8'd20, c_arm);
        guard = 0;
        while (state != 2'd2 && guard < 200) begin step(); guard++; end
        chk("abort_reach_post", 64'(state), 64'd2);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", 64'(state), 64'd0);
        saw_valid = 1'b0;
        repeat (30) begin step(); saw_valid |= rd_valid; end
        chk("abort_no_valid", 64'({saw_valid, done}), 64'd0);
        capture("after_abort", 0, 8'hFF, 8'd40, 0, -1);

        capture("rst_mid_read", 0, 8'hFF, 8'd20, 0, 5);
        capture("after_rst", 1, 8'hFF, 8'(~8'd30), 0, -1);

        capture("mask0", 1, 8'h00, 8'h5A, 0, -1);

        for (int r = 0; r < 4; r++) begin
            fill_rand();
            m  = 8'($urandom) & 8'h13;
            v  = 8'($urandom);
            ti = find_trig(r % 2, m, v);
            if (ti < 0) m = 8'h00;
            capture($sformatf("rand%0d", r), r % 2, m, v, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
